// File: rtl/ce_gen_multi_if.sv
// Control/status bundle for the multi-channel clock-enable generator.
interface ce_gen_multi_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CH_W   = 2,
  parameter int unsigned CNT_W  = 24
);
  logic              iEn;
  logic              iSync;
  logic              iWr;
  logic [CH_W-1:0]   ivWrCh;
  logic [CNT_W-1:0]  ivWrDiv;
  logic [NUM_CH-1:0] oCE;
  logic [NUM_CH-1:0] ovTgl;
  logic [NUM_CH-1:0] ovPending;

  modport master (
    output iEn, iSync, iWr, ivWrCh, ivWrDiv,
    input  oCE, ovTgl, ovPending
  );

  modport slave (
    input  iEn, iSync, iWr, ivWrCh, ivWrDiv,
    output oCE, ovTgl, ovPending
  );
endinterface

// File: rtl/ce_gen_multi.sv
// Multi-channel clock-enable generator: per-channel programmable divisor,
// shadowed reload at the period boundary, global hold and phase realignment.
module ce_gen_multi #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CH_W        = 2,
  parameter int unsigned CNT_W       = 24,
  parameter int unsigned DEFAULT_DIV = 12500000
) (
  input logic           iClk,
  input logic           iRst,
  ce_gen_multi_if.slave bus
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0][CNT_W-1:0] div_q, div_d;
  logic [NUM_CH-1:0][CNT_W-1:0] shadow_q, shadow_d;
  logic [NUM_CH-1:0]            ce_q, ce_d;
  logic [NUM_CH-1:0]            tgl_q, tgl_d;
  logic [NUM_CH-1:0]            pend_q, pend_d;

  // Next-state: sync realign, disabled channel, count/terminal, then write capture.
  always_comb begin
    cnt_d    = cnt_q;
    div_d    = div_q;
    shadow_d = shadow_q;
    ce_d     = '0;
    tgl_d    = tgl_q;
    pend_d   = pend_q;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (bus.iSync) begin
        cnt_d[i] = '0;
        tgl_d[i] = 1'b0;
        if (pend_q[i]) begin
          div_d[i]  = shadow_q[i];
          pend_d[i] = 1'b0;
        end
      end else if (div_q[i] == '0) begin
        // Disabled channel picks up a pending divisor on the next edge, even in hold.
        cnt_d[i] = '0;
        if (pend_q[i]) begin
          div_d[i]  = shadow_q[i];
          pend_d[i] = 1'b0;
        end
      end else if (bus.iEn) begin
        if (cnt_q[i] == div_q[i] - ONE) begin
          cnt_d[i] = '0;
          ce_d[i]  = 1'b1;
          tgl_d[i] = ~tgl_q[i];
          if (pend_q[i]) begin
            div_d[i]  = shadow_q[i];
            pend_d[i] = 1'b0;
          end
        end else begin
          cnt_d[i] = cnt_q[i] + ONE;
        end
      end
      // Channel numbers >= NUM_CH never match any loop index, so they are dropped.
      if (bus.iWr && (bus.ivWrCh == CH_W'(i))) begin
        shadow_d[i] = bus.ivWrDiv;
        pend_d[i]   = 1'b1;
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      cnt_q    <= '0;
      div_q    <= {NUM_CH{DIV_RST}};
      shadow_q <= '0;
      ce_q     <= '0;
      tgl_q    <= '0;
      pend_q   <= '0;
    end else begin
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      shadow_q <= shadow_d;
      ce_q     <= ce_d;
      tgl_q    <= tgl_d;
      pend_q   <= pend_d;
    end
  end

  assign bus.oCE       = ce_q;
  assign bus.ovTgl     = tgl_q;
  assign bus.ovPending = pend_q;

endmodule
